mips32_ram_ctrl: RTL
====================

# mips32_ram_ctrl

Bus responder between the MIPS32 core's data-memory port and a single-port block-RAM instance (MIPS32_RAM, DWIDTH=32, LANES=4). It accepts one word-addressed read or byte-laned write at a time and drives the RAM's registered-read and lane-write ports. It returns read data and a one-cycle ready pulse under a configurable wait-state count. It sits beside the RAM at the standalone top level.

## Interface
- AWIDTH, 12: RAM word-address width. Byte address bits [AWIDTH+1:2] select the word.
- WAIT_STATES, 0: extra cycles inserted before every ready pulse (0..15).
- clock  in  1  single clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- cpuAddr  in  32  byte address; bits [1:0] are ignored.
- cpuRead  in  1  read request level.
- cpuWrite  in  4  write byte-lane mask; any bit set makes the request a write.
- cpuWriteData  in  32  write data, lane i = bits [8i+7:8i].
- cpuReadData  out  32  registered read word.
- cpuReady  out  1  one-cycle completion pulse.
- cpuError  out  1  qualifies cpuReady (bounds feature only).
- ramReadAddr  out  AWIDTH  RAM read address.
- ramReadEnable  out  1  RAM read-address capture.
- ramReadData  in  32  RAM read word, valid the cycle after ramReadEnable.
- ramWriteAddr  out  AWIDTH  RAM write address.
- ramWriteData  out  32  RAM write data.
- ramWriteLane  out  4  RAM byte-lane enables.
- ramWriteEnable  out  1  asserted with any lane enable.

## Operation
- States: IDLE, RD_LAT, WAIT, DONE.
- IDLE: the controller samples the request. Write (cpuWrite≠0) takes priority over cpuRead when both are set; the read is dropped.
- Write accept:
  - Register the address, data and lanes into the ram* outputs.
  - Drive ramWriteEnable/ramWriteLane for exactly one cycle.
  - Then go to WAIT, or to DONE if WAIT_STATES=0.
- Read accept:
  - ramReadEnable is combinational in IDLE when cpuRead is set and no write is requested.
  - ramReadAddr = cpuAddr[AWIDTH+1:2].
  - Go to RD_LAT.
- RD_LAT: capture ramReadData into cpuReadData. Go to WAIT, or to DONE if WAIT_STATES=0.
- WAIT: a down-counter loaded with WAIT_STATES−1 runs to 0. Then go to DONE.
- DONE: cpuReady=1 for one cycle, then IDLE.
- Requests arriving outside IDLE are ignored.
- The core must drop or change its request in the cycle after cpuReady. A request still held in IDLE is treated as new.
- cpuReadData holds its value until the next read capture. Writes do not alter it.
- Sub-word accesses return or write the full word; lane extraction is the core's job.
- Reset: state IDLE, counter 0. All outputs 0, including cpuReadData, ramWrite*, cpuReady and cpuError. A RAM write pending in the same cycle as reset assertion is aborted. An in-flight request is lost and never acknowledged.

## Timing
- The request is sampled in cycle T0 (IDLE).
- Read: RAM address registered at the end of T0. Data captured at the end of T0+1. cpuReady in T0+2+WAIT_STATES.
- Write: ramWriteEnable high in T0+1, and the RAM is updated at the end of T0+1. cpuReady in T0+2+WAIT_STATES.
- Back-to-back throughput: one access per 3+WAIT_STATES cycles. The next request can be accepted in the cycle after cpuReady.
- Read-after-write to the same address returns the new data; the write has completed before the read is issued.

## Configuration
- MIPS32_RAM_CTRL_BOUNDS_EN defined:
  - A request with cpuAddr[31:AWIDTH+2]≠0 performs no RAM access: no ramReadEnable, no ramWriteEnable.
  - It goes straight to DONE, with cpuReady and cpuError high together in T0+1.
  - cpuReadData is loaded with 0 for an out-of-range read.
- Undefined: upper address bits are ignored (the address aliases modulo RAM size), and cpuError is tied to 0.

## Structure
- Package mips32_mem_pkg holds:
  - the state enum;
  - LANES=4 and the 32-bit word width constant;
  - the wait-counter width (4 bits).
- No sub-module; the wait counter is inline. The RAM is instantiated by the parent, not inside this block.

## Test plan
- Reset released, WAIT_STATES=0: write 0xDEADBEEF to 0x40 with lanes 0xF, then read 0x40. Write ready at T0+2, read ready at T0+2 with cpuReadData=0xDEADBEEF.
- Lane write: write 0x000000AA with lanes 0x1 over 0x11223344. A subsequent read returns 0x112233AA.
- WAIT_STATES=3: read 0x80. cpuReady occurs exactly at T0+5, one cycle wide. A request held through DONE is re-executed once.
- cpuRead=1 with cpuWrite=0x3 together: a write occurs, there is no ramReadEnable pulse, and cpuReadData is unchanged.
- Reset asserted in RD_LAT: all outputs 0 immediately, no cpuReady, and the next request after release completes normally.
- Bounds enabled, AWIDTH=12: read 0x00010000 gives cpuReady with cpuError at T0+1, cpuReadData=0, and no RAM strobes. Bounds disabled: the same address aliases to word 0.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 data-memory controller.
package mips32_mem_pkg;

    localparam int LANES      = 4;
    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_LAT = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } ctrlState_e;

    // Any set byte lane turns a request into a write.
    function automatic logic isWriteReq(input logic [LANES-1:0] lanes);
        return |lanes;
    endfunction

endpackage

// File: rtl/mips32_ram_ctrl_if.sv
// Core data-memory bus plus block-RAM port bundle; master is the core/RAM side,
// slave is the controller.
interface mips32_ram_ctrl_if #(
    parameter int AWIDTH = 12
);
    import mips32_mem_pkg::*;

    logic [WORD_W-1:0] cpuAddr;
    logic              cpuRead;
    logic [LANES-1:0]  cpuWrite;
    logic [WORD_W-1:0] cpuWriteData;
    logic [WORD_W-1:0] cpuReadData;
    logic              cpuReady;
    logic              cpuError;
    logic [AWIDTH-1:0] ramReadAddr;
    logic              ramReadEnable;
    logic [WORD_W-1:0] ramReadData;
    logic [AWIDTH-1:0] ramWriteAddr;
    logic [WORD_W-1:0] ramWriteData;
    logic [LANES-1:0]  ramWriteLane;
    logic              ramWriteEnable;

    modport master (
        output cpuAddr, cpuRead, cpuWrite, cpuWriteData, ramReadData,
        input  cpuReadData, cpuReady, cpuError,
        input  ramReadAddr, ramReadEnable, ramWriteAddr, ramWriteData,
        input  ramWriteLane, ramWriteEnable
    );

    modport slave (
        input  cpuAddr, cpuRead, cpuWrite, cpuWriteData, ramReadData,
        output cpuReadData, cpuReady, cpuError,
        output ramReadAddr, ramReadEnable, ramWriteAddr, ramWriteData,
        output ramWriteLane, ramWriteEnable
    );

endinterface

// File: rtl/mips32_ram_ctrl.sv
// Single-outstanding bus responder between the MIPS32 data port and a registered-read block RAM.
// Optional address bounds checking is enabled with `define MIPS32_RAM_CTRL_BOUNDS_EN.
module mips32_ram_ctrl
    import mips32_mem_pkg::*;
#(
    parameter int AWIDTH      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic             clock,
    input  logic             reset,
    mips32_ram_ctrl_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : {WAIT_CNT_W{1'b0}};

    ctrlState_e              state_r;
    logic [WAIT_CNT_W-1:0]   waitCount_r;
    logic                    opWrite_r;
    logic [WORD_W-1:0]       readData_r;
    logic                    ready_r;
    logic                    error_r;
    logic [AWIDTH-1:0]       writeAddr_r;
    logic [WORD_W-1:0]       writeData_r;
    logic [LANES-1:0]        writeLane_r;
    logic                    writeEnable_r;

    logic                    writeReq_s;
    logic                    outOfRange_s;
    logic                    readEnable_s;
    logic                    unusedAddr_s;

    assign writeReq_s = isWriteReq(bus.cpuWrite);

`ifdef MIPS32_RAM_CTRL_BOUNDS_EN
    assign outOfRange_s = |bus.cpuAddr[WORD_W-1:AWIDTH+2];
    assign unusedAddr_s = ^bus.cpuAddr[1:0];
`else
    // Upper address bits alias modulo the RAM size.
    assign outOfRange_s = 1'b0;
    assign unusedAddr_s = ^{bus.cpuAddr[WORD_W-1:AWIDTH+2], bus.cpuAddr[1:0]};
`endif

    // Read strobe is issued straight from the IDLE request so the RAM registers the address in T0.
    always_comb begin
        readEnable_s = 1'b0;
        if (reset && (state_r == IDLE) && bus.cpuRead && !writeReq_s && !outOfRange_s) begin
            readEnable_s = 1'b1;
        end else begin
            readEnable_s = 1'b0;
        end
    end

    assign bus.ramReadEnable  = readEnable_s;
    assign bus.ramReadAddr    = readEnable_s ? bus.cpuAddr[AWIDTH+1:2] : {AWIDTH{1'b0}};
    assign bus.ramWriteAddr   = writeAddr_r;
    assign bus.ramWriteData   = writeData_r;
    assign bus.ramWriteLane   = writeLane_r;
    assign bus.ramWriteEnable = writeEnable_r;
    assign bus.cpuReadData    = readData_r;
    assign bus.cpuReady       = ready_r;
    assign bus.cpuError       = error_r;

    // Access sequencer: RD_LAT doubles as the write strobe cycle, opWrite_r tells the two apart.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            waitCount_r   <= {WAIT_CNT_W{1'b0}};
            opWrite_r     <= 1'b0;
            readData_r    <= {WORD_W{1'b0}};
            ready_r       <= 1'b0;
            error_r       <= 1'b0;
            writeAddr_r   <= {AWIDTH{1'b0}};
            writeData_r   <= {WORD_W{1'b0}};
            writeLane_r   <= {LANES{1'b0}};
            writeEnable_r <= 1'b0;
        end else begin
            ready_r       <= 1'b0;
            error_r       <= 1'b0;
            writeLane_r   <= {LANES{1'b0}};
            writeEnable_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (writeReq_s || bus.cpuRead) begin
                        if (outOfRange_s) begin
                            state_r <= DONE;
                            ready_r <= 1'b1;
                            error_r <= 1'b1;
                            if (!writeReq_s) begin
                                readData_r <= {WORD_W{1'b0}};
                            end
                        end else if (writeReq_s) begin
                            writeAddr_r   <= bus.cpuAddr[AWIDTH+1:2];
                            writeData_r   <= bus.cpuWriteData;
                            writeLane_r   <= bus.cpuWrite;
                            writeEnable_r <= 1'b1;
                            opWrite_r     <= 1'b1;
                            state_r       <= RD_LAT;
                        end else begin
                            opWrite_r <= 1'b0;
                            state_r   <= RD_LAT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_LAT: begin
                    if (!opWrite_r) begin
                        readData_r <= bus.ramReadData;
                    end
                    if (WAIT_STATES == 0) begin
                        state_r <= DONE;
                        ready_r <= 1'b1;
                    end else begin
                        state_r     <= WAIT;
                        waitCount_r <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (waitCount_r == {WAIT_CNT_W{1'b0}}) begin
                        state_r <= DONE;
                        ready_r <= 1'b1;
                    end else begin
                        waitCount_r <= waitCount_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
